// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, word fetch via the controller, halfword issue to the decoder, branch redirect.
// Optional one-word prefetch buffer enabled by defining FETCH_PREFETCH_EN.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch_taken_in,
  input  logic [ADDR_W-1:0] branch_target_in,
  input  logic              stall_mem2fetch_in,
  input  logic              mem_output_valid_in,
  input  logic [31:0]       mem_data_in,
  input  logic              decoder_stall_in,
  output logic              fetch_load_out,
  output logic [ADDR_W-1:0] fetch_addr_out,
  output logic [15:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc_out,
  output logic              instr_valid_out
);

  localparam int unsigned       WORD_W   = 32;
  localparam int unsigned       INSTR_W  = 16;
  localparam logic [ADDR_W-1:0] PC_RST   = RESET_PC & ~ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_RST = RESET_PC & ~ADDR_W'(3);

  typedef enum logic [1:0] {IDLE, REQ, ISSUE, FLUSH} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n, pc_inc, target;
  logic [WORD_W-1:0]   wbuf, wbuf_n;
  logic                resp, accept;
  logic                fetch_load_n, instr_valid_n;
  logic [ADDR_W-1:0]   fetch_addr_n;
  logic [INSTR_W-1:0]  instr_n;
`ifdef FETCH_PREFETCH_EN
  logic [WORD_W-1:0]   pbuf, pbuf_n;
  logic                pbuf_valid, pbuf_valid_n;
`endif

  assign resp   = mem_output_valid_in & ~stall_mem2fetch_in;
  assign accept = fetch_load_out & resp;
  assign pc_inc = pc + ADDR_W'(2);
  assign target = branch_target_in & ~ADDR_W'(1);

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    wbuf_n  = wbuf;
`ifdef FETCH_PREFETCH_EN
    pbuf_n       = pbuf;
    pbuf_valid_n = pbuf_valid;
`endif
    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (branch_taken_in) begin
          pc_n    = target;
          // A response landing in the branch cycle is simply dropped; nothing left to flush.
          state_n = accept ? REQ : FLUSH;
        end else if (accept) begin
          wbuf_n  = mem_data_in;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
`ifdef FETCH_PREFETCH_EN
        if (branch_taken_in) begin
          pc_n         = target;
          pbuf_valid_n = 1'b0;
          state_n      = (fetch_load_out && !accept) ? FLUSH : REQ;
        end else begin
          if (accept) begin
            pbuf_n       = mem_data_in;
            pbuf_valid_n = 1'b1;
          end
          if (!decoder_stall_in) begin
            pc_n = pc_inc;
            if (pc[1]) begin
              if (pbuf_valid_n) begin
                wbuf_n       = pbuf_n;
                pbuf_valid_n = 1'b0;
              end else begin
                state_n = REQ;
              end
            end
          end
        end
`else
        if (branch_taken_in) begin
          pc_n    = target;
          state_n = REQ;
        end else if (!decoder_stall_in) begin
          pc_n = pc_inc;
          if (pc[1]) state_n = REQ;
        end
`endif
      end
      FLUSH: begin
        if (branch_taken_in) pc_n = target;
        if (resp) state_n = REQ;
      end
      default: state_n = IDLE;
    endcase

    fetch_load_n  = (state_n == REQ);
    fetch_addr_n  = pc_n & ~ADDR_W'(3);
    instr_valid_n = (state_n == ISSUE);
    instr_n       = pc_n[1] ? wbuf_n[31:16] : wbuf_n[15:0];
`ifdef FETCH_PREFETCH_EN
    // While issuing, the request line points at the following word until pbuf is filled.
    if (state_n == ISSUE) begin
      fetch_load_n = !pbuf_valid_n;
      fetch_addr_n = fetch_addr_n + ADDR_W'(4);
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      pc              <= PC_RST;
      wbuf            <= '0;
      fetch_load_out  <= 1'b0;
      fetch_addr_out  <= ADDR_RST;
      instr_out       <= '0;
      instr_pc_out    <= PC_RST;
      instr_valid_out <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      pbuf            <= '0;
      pbuf_valid      <= 1'b0;
`endif
    end else begin
      state           <= state_n;
      pc              <= pc_n;
      wbuf            <= wbuf_n;
      fetch_load_out  <= fetch_load_n;
      fetch_addr_out  <= fetch_addr_n;
      instr_out       <= instr_n;
      instr_pc_out    <= pc_n;
      instr_valid_out <= instr_valid_n;
`ifdef FETCH_PREFETCH_EN
      pbuf            <= pbuf_n;
      pbuf_valid      <= pbuf_valid_n;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (RESET_PC = 0x12); inputs driven and outputs sampled on the falling edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_taken_in;
  logic [31:0] branch_target_in;
  logic        stall_mem2fetch_in;
  logic        mem_output_valid_in;
  logic [31:0] mem_data_in;
  logic        decoder_stall_in;
  logic        fetch_load_out;
  logic [31:0] fetch_addr_out;
  logic [15:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        instr_valid_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h12)) dut (
    .clk                 (clk),
    .reset               (reset),
    .branch_taken_in     (branch_taken_in),
    .branch_target_in    (branch_target_in),
    .stall_mem2fetch_in  (stall_mem2fetch_in),
    .mem_output_valid_in (mem_output_valid_in),
    .mem_data_in         (mem_data_in),
    .decoder_stall_in    (decoder_stall_in),
    .fetch_load_out      (fetch_load_out),
    .fetch_addr_out      (fetch_addr_out),
    .instr_out           (instr_out),
    .instr_pc_out        (instr_pc_out),
    .instr_valid_out     (instr_valid_out)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_req(input string tag, input logic [31:0] addr);
    chk({tag, "_load"}, 32'(fetch_load_out), 32'd1);
    chk({tag, "_addr"}, fetch_addr_out, addr);
    chk({tag, "_valid"}, 32'(instr_valid_out), 32'd0);
  endtask

  task automatic expect_issue(input string tag, input logic [15:0] ins, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(instr_valid_out), 32'd1);
    chk({tag, "_instr"}, 32'(instr_out), 32'(ins));
    chk({tag, "_pc"}, instr_pc_out, pc);
  endtask

  // One-cycle memory response presented on the next rising edge.
  task automatic respond(input logic [31:0] word);
    mem_output_valid_in = 1'b1;
    mem_data_in         = word;
    tick();
    mem_output_valid_in = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_load"}, 32'(fetch_load_out), 32'd0);
    chk({tag, "_addr"}, fetch_addr_out, 32'h10);
    chk({tag, "_instr"}, 32'(instr_out), 32'd0);
    chk({tag, "_pc"}, instr_pc_out, 32'h12);
    chk({tag, "_valid"}, 32'(instr_valid_out), 32'd0);
  endtask

  initial begin
    reset               = 1'b0;
    branch_taken_in     = 1'b0;
    branch_target_in    = '0;
    stall_mem2fetch_in  = 1'b0;
    mem_output_valid_in = 1'b0;
    mem_data_in         = '0;
    decoder_stall_in    = 1'b0;
    tick();
    tick();
    check_reset_values("rst");

    reset = 1'b1;
    tick();
    expect_req("odd_req", 32'h10);
    respond(32'hBBBBAAAA);
    expect_issue("odd_issue", 16'hBBBB, 32'h12);

`ifdef FETCH_PREFETCH_EN
    // Prefetch of 0x14 lands in the same cycle the upper halfword is consumed.
    chk("pf_load0", 32'(fetch_load_out), 32'd1);
    chk("pf_addr0", fetch_addr_out, 32'h14);
    respond(32'hDDDDCCCC);
    expect_issue("pf_i0", 16'hCCCC, 32'h14);
    chk("pf_load1", 32'(fetch_load_out), 32'd1);
    chk("pf_addr1", fetch_addr_out, 32'h18);
    respond(32'hFFFFEEEE);
    expect_issue("pf_i1", 16'hDDDD, 32'h16);
    chk("pf_load2", 32'(fetch_load_out), 32'd0);
    tick();
    expect_issue("pf_i2", 16'hEEEE, 32'h18);
    chk("pf_addr3", fetch_addr_out, 32'h1C);
`else
    tick();
    expect_req("odd_next", 32'h14);

    // Branch while the 0x14 request is outstanding: response discarded.
    branch_taken_in  = 1'b1;
    branch_target_in = 32'h0;
    tick();
    branch_taken_in  = 1'b0;
    chk("flush_load", 32'(fetch_load_out), 32'd0);
    chk("flush_valid", 32'(instr_valid_out), 32'd0);
    chk("flush_pc", instr_pc_out, 32'h0);
    respond(32'hDEADBEEF);
    expect_req("seq_req0", 32'h0);

    // Memory stall: valid data is ignored and the request holds.
    stall_mem2fetch_in  = 1'b1;
    mem_output_valid_in = 1'b1;
    mem_data_in         = 32'hBBBBAAAA;
    tick();
    expect_req("mstall1", 32'h0);
    tick();
    expect_req("mstall2", 32'h0);
    stall_mem2fetch_in = 1'b0;
    tick();
    mem_output_valid_in = 1'b0;
    expect_issue("seq_i0", 16'hAAAA, 32'h0);

    decoder_stall_in = 1'b1;
    repeat (3) begin
      tick();
      expect_issue("dstall", 16'hAAAA, 32'h0);
    end
    decoder_stall_in = 1'b0;
    tick();
    expect_issue("seq_i1", 16'hBBBB, 32'h2);
    tick();
    expect_req("seq_req1", 32'h4);
    respond(32'hDDDDCCCC);
    expect_issue("seq_i2", 16'hCCCC, 32'h4);
    tick();
    expect_issue("seq_i3", 16'hDDDD, 32'h6);
    tick();
    expect_req("seq_req2", 32'h8);

    // Branch during ISSUE wins over the decoder handshake.
    respond(32'h22221111);
    expect_issue("br_pre", 16'h1111, 32'h8);
    branch_taken_in  = 1'b1;
    branch_target_in = 32'h101;
    tick();
    branch_taken_in  = 1'b0;
    expect_req("br_req", 32'h100);
    chk("br_pc", instr_pc_out, 32'h100);
    respond(32'h44443333);
    expect_issue("br_i0", 16'h3333, 32'h100);
    tick();
    expect_issue("br_i1", 16'h4444, 32'h102);
    tick();
    expect_req("br_req2", 32'h104);

    branch_taken_in  = 1'b1;
    branch_target_in = 32'h40;
    tick();
    branch_taken_in  = 1'b0;
    chk("fl2_load", 32'(fetch_load_out), 32'd0);
    respond(32'h66665555);
    expect_req("fl2_req", 32'h40);
    respond(32'h88887777);
    expect_issue("fl2_i0", 16'h7777, 32'h40);

    // PC wraps silently from 0xFFFFFFFE to 0.
    branch_taken_in  = 1'b1;
    branch_target_in = 32'hFFFFFFFE;
    tick();
    branch_taken_in  = 1'b0;
    expect_req("wrap_req", 32'hFFFFFFFC);
    respond(32'hBEEF0000);
    expect_issue("wrap_i", 16'hBEEF, 32'hFFFFFFFE);
    tick();
    expect_req("wrap_next", 32'h0);
    respond(32'h5A5A1234);
    expect_issue("pre_rst", 16'h1234, 32'h0);
`endif

    // Asynchronous reset between clock edges.
    #2 reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
